operand_fetch_stage: RTL and testbench

- Decode-to-execute pipeline stage wrapped around the 32x32 register file.
- Drives the file's A/B read addresses from the decoded Rs/Rt and consumes the returned A_Data/B_Data.
- Applies EX/MEM/WB forwarding and load-use stall detection, then registers the resolved operands for the execute stage behind a valid/ready handshake.
- One-entry pipeline register; 1-cycle latency; full throughput when no hazard.

---
 rtl/operand_fetch_stage.sv | 128 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: sits between decode and execute, drives the register
// file read ports, resolves EX/MEM/WB forwarding, detects load-use hazards
// and holds the resolved operands in a one-entry valid/ready pipeline register.
module operand_fetch_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    // decode side
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [ADDR_WIDTH-1:0]      Rs_Address,
    input  logic [ADDR_WIDTH-1:0]      Rt_Address,
    input  logic                       Uses_Rt,
    input  logic [ADDR_WIDTH-1:0]      Rd_Address,
    input  logic                       Rd_Write,
    input  logic                       Is_Load,
    // register file read ports
    output logic [ADDR_WIDTH-1:0]      A_Address,
    output logic [ADDR_WIDTH-1:0]      B_Address,
    input  logic [DATA_WIDTH-1:0]      A_Data,
    input  logic [DATA_WIDTH-1:0]      B_Data,
    // forwarding sources
    input  logic                       Ex_Write,
    input  logic                       Ex_Is_Load,
    input  logic [ADDR_WIDTH-1:0]      Ex_Address,
    input  logic [DATA_WIDTH-1:0]      Ex_Data,
    input  logic                       Mem_Write,
    input  logic [ADDR_WIDTH-1:0]      Mem_Address,
    input  logic [DATA_WIDTH-1:0]      Mem_Data,
    input  logic                       Wb_Write,
    input  logic [ADDR_WIDTH-1:0]      Wb_Address,
    input  logic [DATA_WIDTH-1:0]      Wb_Data,
    // control
    input  logic                       Flush,
    // execute side
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [DATA_WIDTH-1:0]      Out_A,
    output logic [DATA_WIDTH-1:0]      Out_B,
    output logic [ADDR_WIDTH-1:0]      Out_Rd_Address,
    output logic                       Out_Rd_Write,
    output logic                       Out_Is_Load,
    output logic [STALL_CNT_WIDTH-1:0] Stall_Count
);

    localparam logic [ADDR_WIDTH-1:0]      ZERO_REG  = '0;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

    logic                  hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] resolved_a;
    logic [DATA_WIDTH-1:0] resolved_b;

    // Pick the youngest in-flight value for one source register. An EX load
    // cannot forward (its data does not exist yet), so it falls through to the
    // older stages; the hazard logic stalls whenever that value would be used.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [ADDR_WIDTH-1:0] src,
        input logic [DATA_WIDTH-1:0] file_data
    );
        logic [DATA_WIDTH-1:0] value;
        value = file_data;
        if (src == ZERO_REG)
            value = '0;
        else if (Ex_Write && !Ex_Is_Load && Ex_Address == src)
            value = Ex_Data;
        else if (Mem_Write && Mem_Address == src)
            value = Mem_Data;
        else if (Wb_Write && Wb_Address == src)
            // the file only updates on this edge, so its read data is still old
            value = Wb_Data;
        return value;
    endfunction

    assign A_Address = Rs_Address;
    assign B_Address = Rt_Address;

    // Load-use detection, operand resolution and the decode-side handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        hazard     = 1'b0;
        resolved_a = resolve(Rs_Address, A_Data);
        resolved_b = resolve(Rt_Address, B_Data);
        if (Ex_Write && Ex_Is_Load && Ex_Address != ZERO_REG) begin
            hazard = (Ex_Address == Rs_Address) ||
                     (Uses_Rt && Ex_Address == Rt_Address);
        end
        In_Ready = !Flush && !hazard && (!Out_Valid || Out_Ready);
    end

    assign accept = In_Valid && In_Ready;

    // Pipeline register: flush beats capture, capture beats drain.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            Out_Valid      <= 1'b0;
            Out_A          <= '0;
            Out_B          <= '0;
            Out_Rd_Address <= '0;
            Out_Rd_Write   <= 1'b0;
            Out_Is_Load    <= 1'b0;
        end else if (Flush) begin
            Out_Valid <= 1'b0;
        end else if (accept) begin
            Out_Valid      <= 1'b1;
            Out_A          <= resolved_a;
            Out_B          <= resolved_b;
            Out_Rd_Address <= Rd_Address;
            Out_Rd_Write   <= Rd_Write;
            Out_Is_Load    <= Is_Load;
        end else if (Out_Valid && Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

    // Saturating count of cycles a valid instruction waits on a load-use hazard.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Stall_Count <= '0;
        else if (In_Valid && hazard && !Flush && Stall_Count != STALL_MAX)
            Stall_Count <= Stall_Count + 1'b1;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural 32x32 register file.
module tb_operand_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid, In_Ready;
    logic [4:0]  Rs_Address, Rt_Address, Rd_Address;
    logic        Uses_Rt, Rd_Write, Is_Load;
    logic [4:0]  A_Address, B_Address;
    logic [31:0] A_Data, B_Data;
    logic        Ex_Write, Ex_Is_Load;
    logic [4:0]  Ex_Address;
    logic [31:0] Ex_Data;
    logic        Mem_Write;
    logic [4:0]  Mem_Address;
    logic [31:0] Mem_Data;
    logic        Wb_Write;
    logic [4:0]  Wb_Address;
    logic [31:0] Wb_Data;
    logic        Flush;
    logic        Out_Valid, Out_Ready;
    logic [31:0] Out_A, Out_B;
    logic [4:0]  Out_Rd_Address;
    logic        Out_Rd_Write, Out_Is_Load;
    logic [15:0] Stall_Count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] regs [32];

    always #5 Clk = ~Clk;

    // Register file: written at the WB edge, read combinationally, R0 reads zero.
    always_ff @(posedge Clk) begin
        if (Wb_Write && Wb_Address != 5'd0)
            regs[Wb_Address] <= Wb_Data;
    end
    assign A_Data = (A_Address == 5'd0) ? 32'd0 : regs[A_Address];
    assign B_Data = (B_Address == 5'd0) ? 32'd0 : regs[B_Address];

    operand_fetch_stage dut (
        .Clk(Clk), .Reset(Reset),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Rs_Address(Rs_Address), .Rt_Address(Rt_Address), .Uses_Rt(Uses_Rt),
        .Rd_Address(Rd_Address), .Rd_Write(Rd_Write), .Is_Load(Is_Load),
        .A_Address(A_Address), .B_Address(B_Address),
        .A_Data(A_Data), .B_Data(B_Data),
        .Ex_Write(Ex_Write), .Ex_Is_Load(Ex_Is_Load), .Ex_Address(Ex_Address), .Ex_Data(Ex_Data),
        .Mem_Write(Mem_Write), .Mem_Address(Mem_Address), .Mem_Data(Mem_Data),
        .Wb_Write(Wb_Write), .Wb_Address(Wb_Address), .Wb_Data(Wb_Data),
        .Flush(Flush),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_A(Out_A), .Out_B(Out_B),
        .Out_Rd_Address(Out_Rd_Address), .Out_Rd_Write(Out_Rd_Write), .Out_Is_Load(Out_Is_Load),
        .Stall_Count(Stall_Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_fwd();
        Ex_Write = 0; Ex_Is_Load = 0; Ex_Address = 0; Ex_Data = 0;
        Mem_Write = 0; Mem_Address = 0; Mem_Data = 0;
        Wb_Write = 0; Wb_Address = 0; Wb_Data = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        Reset = 1; In_Valid = 0; Rs_Address = 0; Rt_Address = 0; Uses_Rt = 0;
        Rd_Address = 0; Rd_Write = 0; Is_Load = 0; Flush = 0; Out_Ready = 1;
        clear_fwd();
        #12;
        check("reset_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("reset_stall", {16'd0, Stall_Count}, 32'd0);
        Reset = 0;
        step();

        // Preload R5 = 0x11 and R3 = 0x33 through the WB port.
        Wb_Write = 1; Wb_Address = 5; Wb_Data = 32'h11;
        step();
        Wb_Address = 3; Wb_Data = 32'h33;
        step();
        clear_fwd();

        // File read with no forwarding.
        Rs_Address = 5; Rt_Address = 0; In_Valid = 1;
        #1;
        check("addr_a", {27'd0, A_Address}, 32'd5);
        check("ready_idle", {31'd0, In_Ready}, 32'd1);
        step();
        check("file_valid", {31'd0, Out_Valid}, 32'd1);
        check("file_a", Out_A, 32'h11);
        check("file_b", Out_B, 32'h0);

        // Forward priority EX > MEM > WB on Rs = 7.
        Rs_Address = 7;
        Ex_Write = 1; Ex_Address = 7; Ex_Data = 32'hAAAA;
        Mem_Write = 1; Mem_Address = 7; Mem_Data = 32'hBBBB;
        Wb_Write = 1; Wb_Address = 7; Wb_Data = 32'hCCCC;
        step();
        check("prio_ex", Out_A, 32'hAAAA);
        Ex_Write = 0;
        step();
        check("prio_mem", Out_A, 32'hBBBB);
        Mem_Write = 0;
        step();
        check("prio_wb", Out_A, 32'hCCCC);

        // Fresh WB write whose value is not yet in the file.
        clear_fwd();
        Rs_Address = 9; Wb_Write = 1; Wb_Address = 9; Wb_Data = 32'h1234;
        step();
        check("wb_bypass", Out_A, 32'h1234);
        clear_fwd();

        // Load-use on Rt.
        Rs_Address = 1; Rt_Address = 3; Uses_Rt = 1;
        Ex_Write = 1; Ex_Is_Load = 1; Ex_Address = 3; Ex_Data = 32'hDEAD;
        #1;
        check("lu_ready", {31'd0, In_Ready}, 32'd0);
        step();
        check("lu_stall1", {16'd0, Stall_Count}, 32'd1);
        check("lu_no_capture", {31'd0, Out_Valid}, 32'd0);
        Ex_Write = 0; Ex_Is_Load = 0;
        Mem_Write = 1; Mem_Address = 3; Mem_Data = 32'h3333;
        #1;
        check("lu_clear_ready", {31'd0, In_Ready}, 32'd1);
        step();
        check("lu_capture_valid", {31'd0, Out_Valid}, 32'd1);
        check("lu_capture_b", Out_B, 32'h3333);
        check("lu_stall_hold", {16'd0, Stall_Count}, 32'd1);
        clear_fwd();

        // Same EX load on Rt but Rt unused: no stall.
        Uses_Rt = 0; Ex_Write = 1; Ex_Is_Load = 1; Ex_Address = 3;
        #1;
        check("no_rt_ready", {31'd0, In_Ready}, 32'd1);
        step();
        check("no_rt_stall", {16'd0, Stall_Count}, 32'd1);

        // Register 0 never stalls and always reads zero.
        Rs_Address = 0; Rt_Address = 0; Uses_Rt = 1;
        Ex_Write = 1; Ex_Is_Load = 1; Ex_Address = 0; Ex_Data = 32'hFFFF;
        Mem_Write = 1; Mem_Address = 0; Mem_Data = 32'hEEEE;
        #1;
        check("r0_ready", {31'd0, In_Ready}, 32'd1);
        step();
        check("r0_a", Out_A, 32'h0);
        check("r0_stall", {16'd0, Stall_Count}, 32'd1);
        clear_fwd();

        // Backpressure: capture one instruction, then hold it for 3 cycles.
        Rs_Address = 5; Rt_Address = 7; Uses_Rt = 1;
        Rd_Address = 10; Rd_Write = 1; Is_Load = 1;
        step();
        check("bp_capture_a", Out_A, 32'h11);
        Out_Ready = 0;
        Rs_Address = 3; Rt_Address = 9; Rd_Address = 4; Rd_Write = 0; Is_Load = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", {31'd0, In_Ready}, 32'd0);
            step();
            check("bp_valid", {31'd0, Out_Valid}, 32'd1);
            check("bp_a", Out_A, 32'h11);
            check("bp_b", Out_B, 32'hCCCC);
            check("bp_rd", {27'd0, Out_Rd_Address}, 32'd10);
            check("bp_ctl", {30'd0, Out_Rd_Write, Out_Is_Load}, 32'd3);
        end

        // Flush squashes the held entry and blocks capture.
        Flush = 1; Out_Ready = 1;
        #1;
        check("flush_ready", {31'd0, In_Ready}, 32'd0);
        step();
        check("flush_valid", {31'd0, Out_Valid}, 32'd0);
        Flush = 0;

        // Reset mid-transfer: capture, stall output, then assert reset between edges.
        Rs_Address = 5; Rt_Address = 0;
        Ex_Write = 1; Ex_Is_Load = 1; Ex_Address = 5;
        step();
        check("pre_rst_stall", {16'd0, Stall_Count}, 32'd2);
        clear_fwd();
        step();
        check("pre_rst_valid", {31'd0, Out_Valid}, 32'd1);
        Out_Ready = 0; In_Valid = 0;
        #2;
        Reset = 1;
        #1;
        check("rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_a", Out_A, 32'd0);
        check("rst_b", Out_B, 32'd0);
        check("rst_rd", {25'd0, Out_Rd_Address, Out_Rd_Write, Out_Is_Load}, 32'd0);
        check("rst_stall", {16'd0, Stall_Count}, 32'd0);
        Reset = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
